// File: rtl/usbh_gamepad_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : usbh_gamepad_pkg
//  Brief    : Shared widths, defaults and arbiter state encoding for the
//             USB host gamepad report path.
//  Revision : 1.0 - initial release
// ============================================================================
package usbh_gamepad_pkg;

    localparam int BTN_W                  = 12;
    localparam int REPORT_W               = 64;
    localparam int TIMEOUT_CYCLES_DEFAULT = 2400000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/usbh_report_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : usbh_report_arbiter_if
//  Brief     : Link between the report arbiter and the shared HID decoder.
//              The arbiter is the master (drives report + strobe), the
//              decoder is the slave (returns the button word).
//  Revision  : 1.0 - initial release
// ============================================================================
interface usbh_report_arbiter_if;
    import usbh_gamepad_pkg::*;

    logic [REPORT_W-1:0] dec_report;
    logic                dec_valid;
    logic [BTN_W-1:0]    dec_btn;

    modport master (output dec_report, output dec_valid, input dec_btn);
    modport slave  (input dec_report, input dec_valid, output dec_btn);

endinterface
`default_nettype wire

// File: rtl/usbh_report_slot.sv
`default_nettype none
// ============================================================================
//  Module   : usbh_report_slot
//  Brief    : Per-port state: one-deep report buffer, pending flag, overrun
//             pulse, liveness timeout and the pad's button output register.
//  Revision : 1.0 - initial release
// ============================================================================
module usbh_report_slot
    import usbh_gamepad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [REPORT_W-1:0] i_report,
    input  logic                i_report_valid,
    input  logic                i_issue,
    input  logic                i_capture,
    input  logic [BTN_W-1:0]    i_dec_btn,
    output logic [REPORT_W-1:0] o_buf_next,
    output logic                o_pending,
    output logic                o_overrun,
    output logic                o_present,
    output logic                o_update,
    output logic [BTN_W-1:0]    o_btn
);

    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_TMAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_TPRE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [REPORT_W-1:0] buf_q, buf_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                present_q, present_d;
    logic [BTN_W-1:0]    btn_q, btn_d;
    logic                update_q, update_d;
    logic                w_timeout_hit;

    // Next-state for buffer, pending/overrun, liveness counter and button word
    always_comb begin
        buf_d     = i_report_valid ? i_report : buf_q;
        pending_d = pending_q;
        if (i_report_valid) begin
            pending_d = 1'b1;
        end else if (i_issue) begin
            pending_d = 1'b0;
        end
        // During ISSUE the old report has already been handed out, so a
        // same-cycle strobe replaces nothing that was still waiting.
        overrun_d = i_report_valid & pending_q & ~i_issue;

        w_timeout_hit = ~i_report_valid && (cnt_q == c_TPRE);
        cnt_d = cnt_q;
        if (i_report_valid) begin
            cnt_d = '0;
        end else if (cnt_q != c_TMAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        btn_d     = btn_q;
        present_d = present_q;
        if (i_capture) begin
            btn_d     = i_dec_btn;
            present_d = 1'b1;
        end else if (w_timeout_hit) begin
            btn_d     = '0;
            present_d = 1'b0;
        end
        update_d = i_capture;
    end

    // Slot state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            present_q <= 1'b0;
            btn_q     <= '0;
            update_q  <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            present_q <= present_d;
            btn_q     <= btn_d;
            update_q  <= update_d;
        end
    end

    // Arbiter loads the decoder from the next-state buffer so a strobe in the
    // grant cycle is what actually gets issued (newest report wins).
    assign o_buf_next = buf_d;
    assign o_pending  = pending_q;
    assign o_overrun  = overrun_q;
    assign o_present  = present_q;
    assign o_update   = update_q;
    assign o_btn      = btn_q;

endmodule
`default_nettype wire

// File: rtl/usbh_report_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : usbh_report_arbiter
//  Brief    : Round-robin sharing of one gamepad HID decoder between two USB
//             host ports, with per-pad button registers and liveness.
//  Revision : 1.0 - initial release
// ============================================================================
module usbh_report_arbiter
    import usbh_gamepad_pkg::*;
#(
    parameter int DEC_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REPORT_W-1:0]   i_report0,
    input  logic                  i_report0_valid,
    input  logic [REPORT_W-1:0]   i_report1,
    input  logic                  i_report1_valid,
    usbh_report_arbiter_if.master dec,
    output logic [BTN_W-1:0]      o_btn0,
    output logic [BTN_W-1:0]      o_btn1,
    output logic [1:0]            o_present,
    output logic [1:0]            o_update,
    output logic [1:0]            o_overrun
);

    localparam logic [2:0] c_LAT = 3'(DEC_LATENCY);

    arb_state_e          state_q, state_d;
    logic                grant_q, grant_d;
    logic                rr_last_q, rr_last_d;
    logic [2:0]          wait_q, wait_d;
    logic                dec_valid_q, dec_valid_d;
    logic [REPORT_W-1:0] dec_report_q, dec_report_d;

    logic [REPORT_W-1:0] w_report   [2];
    logic [REPORT_W-1:0] w_buf_next [2];
    logic [BTN_W-1:0]    w_btn      [2];
    logic [1:0]          w_report_valid;
    logic [1:0]          w_pending;
    logic [1:0]          w_issue;
    logic [1:0]          w_capture;

    assign w_report[0]    = i_report0;
    assign w_report[1]    = i_report1;
    assign w_report_valid = {i_report1_valid, i_report0_valid};

    for (genvar n = 0; n < 2; n++) begin : g_slot
        usbh_report_slot #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slot (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_report       (w_report[n]),
            .i_report_valid (w_report_valid[n]),
            .i_issue        (w_issue[n]),
            .i_capture      (w_capture[n]),
            .i_dec_btn      (dec.dec_btn),
            .o_buf_next     (w_buf_next[n]),
            .o_pending      (w_pending[n]),
            .o_overrun      (o_overrun[n]),
            .o_present      (o_present[n]),
            .o_update       (o_update[n]),
            .o_btn          (w_btn[n])
        );
    end

    // Arbitration FSM: grant, issue one report, wait out decoder latency
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_last_d    = rr_last_q;
        wait_d       = wait_q;
        dec_valid_d  = 1'b0;
        dec_report_d = dec_report_q;
        w_issue      = '0;
        w_capture    = '0;
        case (state_q)
            IDLE: begin
                if (|w_pending) begin
                    grant_d      = (w_pending == 2'b11) ? ~rr_last_q : w_pending[1];
                    rr_last_d    = grant_d;
                    dec_valid_d  = 1'b1;
                    dec_report_d = grant_d ? w_buf_next[1] : w_buf_next[0];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                w_issue[grant_q] = 1'b1;
                wait_d           = c_LAT;
                state_d          = WAIT;
            end
            WAIT: begin
                if (wait_q == 3'd1) begin
                    w_capture[grant_q] = 1'b1;
                    state_d            = IDLE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and decoder-facing registers; rr_last resets to 1 so port 0 wins first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            wait_q       <= '0;
            dec_valid_q  <= 1'b0;
            dec_report_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_last_q    <= rr_last_d;
            wait_q       <= wait_d;
            dec_valid_q  <= dec_valid_d;
            dec_report_q <= dec_report_d;
        end
    end

    assign dec.dec_valid  = dec_valid_q;
    assign dec.dec_report = dec_report_q;
    assign o_btn0         = w_btn[0];
    assign o_btn1         = w_btn[1];

endmodule
`default_nettype wire

// File: tb/tb_usbh_report_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usbh_report_arbiter
//  Brief    : Self-checking bench for usbh_report_arbiter with a stub decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usbh_report_arbiter;
    import usbh_gamepad_pkg::*;

    typedef struct packed {
        logic        port;
        logic [11:0] btn;
        logic        present;
    } upd_t;

    typedef struct {
        bit          v0;
        bit          v1;
        logic [63:0] d0;
        logic [63:0] d1;
        bit          exp_first;
        int          exp_n;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rep0  = '0;
    logic [63:0] rep1  = '0;
    logic        v0    = 1'b0;
    logic        v1    = 1'b0;
    logic [11:0] btn0, btn1;
    logic [1:0]  present, update, overrun;

    usbh_report_arbiter_if dec_if ();

    usbh_report_arbiter #(
        .DEC_LATENCY    (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_report0       (rep0),
        .i_report0_valid (v0),
        .i_report1       (rep1),
        .i_report1_valid (v1),
        .dec             (dec_if),
        .o_btn0          (btn0),
        .o_btn1          (btn1),
        .o_present       (present),
        .o_update        (update),
        .o_overrun       (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dec_f(input logic [63:0] r);
        return r[11:0] ^ r[55:44];
    endfunction

    // Stub decoder: one cycle from strobe to result
    always @(posedge clk) begin
        if (dec_if.dec_valid) dec_if.dec_btn <= dec_f(dec_if.dec_report);
    end

    // Monitor: logs DUT output events
    upd_t        upd_log[$];
    logic [63:0] iss_log[$];
    int          conc_cnt   = 0;
    int          long_cnt   = 0;
    int          ovr0       = 0;
    int          ovr1       = 0;
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        if (update[0]) upd_log.push_back('{1'b0, btn0, present[0]});
        if (update[1]) upd_log.push_back('{1'b1, btn1, present[1]});
        if (dec_if.dec_valid) iss_log.push_back(dec_if.dec_report);
        conc_cnt   <= conc_cnt + ((update == 2'b11) ? 1 : 0);
        long_cnt   <= long_cnt + ((dec_if.dec_valid && prev_valid) ? 1 : 0);
        prev_valid <= dec_if.dec_valid;
        ovr0       <= ovr0 + (overrun[0] ? 1 : 0);
        ovr1       <= ovr1 + (overrun[1] ? 1 : 0);
    end

    // Scoreboard
    logic [11:0] exp0[$];
    logic [11:0] exp1[$];
    int          upd_rd = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input bit a, input logic [63:0] da, input bit pa,
                          input bit b, input logic [63:0] db, input bit pb);
        if (a) rep0 = da;
        if (b) rep1 = db;
        v0 = a;
        v1 = b;
        if (a && pa) exp0.push_back(dec_f(da));
        if (b && pb) exp1.push_back(dec_f(db));
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        upd_t        u;
        logic [11:0] e;
        while (upd_rd < upd_log.size()) begin
            u = upd_log[upd_rd];
            upd_rd++;
            check({name, "_present_at_update"}, 64'(u.present), 64'd1);
            if ((u.port ? exp1.size() : exp0.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_extra_update: pad %0d got %0h, expected no update", name, u.port, u.btn);
            end else if (u.port) begin
                e = exp1.pop_front();
                check({name, "_btn1"}, 64'(u.btn), 64'(e));
            end else begin
                e = exp0.pop_front();
                check({name, "_btn0"}, 64'(u.btn), 64'(e));
            end
        end
        check({name, "_missing_updates0"}, 64'(exp0.size()), 64'd0);
        check({name, "_missing_updates1"}, 64'(exp1.size()), 64'd0);
        exp0.delete();
        exp1.delete();
    endtask

    vec_t        vecs[6];
    int          b, o0, o1, u0;
    logic [63:0] fair_exp[5];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 64'h0000_0000_0000_0A5C, 64'h0000_0000_0000_0B17, 1'b0, 2};
        vecs[1] = '{1'b0, 1'b1, 64'h0, 64'h0030_1000_0000_0C01, 1'b1, 1};
        vecs[2] = '{1'b1, 1'b1, 64'h00F0_0000_0000_0123, 64'h0A00_0000_0000_0456, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b1, 64'h0000_1111_2222_3333, 64'h4444_5555_6666_7777, 1'b1, 2};
        vecs[5] = '{1'b0, 1'b1, 64'h0, 64'h00AB_C000_0000_0FFF, 1'b1, 1};

        // Reset values
        ticks(2);
        check("rst_btn0", 64'(btn0), 64'd0);
        check("rst_btn1", 64'(btn1), 64'd0);
        check("rst_present", 64'(present), 64'd0);
        check("rst_update", 64'(update), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_dec_valid", 64'(dec_if.dec_valid), 64'd0);
        check("rst_dec_report", dec_if.dec_report, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single report: hat=2, bit44 set; update at strobe+4
        strobe(1'b1, 64'h0000_1000_0000_0002, 1'b1, 1'b0, 64'h0, 1'b0);
        check("single_dv_t1", 64'(dec_if.dec_valid), 64'd0);
        tick();
        check("single_dv_t2", 64'(dec_if.dec_valid), 64'd1);
        check("single_report", dec_if.dec_report, 64'h0000_1000_0000_0002);
        tick();
        check("single_dv_t3", 64'(dec_if.dec_valid), 64'd0);
        check("single_upd_t3", 64'(update), 64'd0);
        tick();
        check("single_upd_t4", 64'(update), 64'b01);
        check("single_btn0", 64'(btn0), 64'h003);
        check("single_present", 64'(present), 64'b01);
        tick();
        check("single_upd_t5", 64'(update), 64'd0);
        drain("single");

        // Table: single and simultaneous strobes, round-robin order
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b  = iss_log.size();
            o0 = ovr0;
            o1 = ovr1;
            strobe(vecs[i].v0, vecs[i].d0, 1'b1, vecs[i].v1, vecs[i].d1, 1'b1);
            ticks(10);
            check($sformatf("vec%0d_issues", i), 64'(iss_log.size() - b), 64'(vecs[i].exp_n));
            check($sformatf("vec%0d_first", i), iss_log[b], vecs[i].exp_first ? vecs[i].d1 : vecs[i].d0);
            if (vecs[i].exp_n == 2)
                check($sformatf("vec%0d_second", i), iss_log[b+1], vecs[i].exp_first ? vecs[i].d0 : vecs[i].d1);
            check($sformatf("vec%0d_overrun", i), 64'((ovr0 - o0) + (ovr1 - o1)), 64'd0);
            drain($sformatf("vec%0d", i));
        end

        // Fairness: port 0 strobes every 3 cycles, port 1 keeps getting turns
        do_reset();
        b  = iss_log.size();
        o0 = ovr0;
        o1 = ovr1;
        fair_exp = '{64'hA0, 64'hB0, 64'hA2, 64'hB1, 64'hA3};
        strobe(1'b1, 64'hA0, 1'b1, 1'b1, 64'hB0, 1'b1);
        ticks(2);
        strobe(1'b1, 64'hA1, 1'b0, 1'b0, 64'h0, 1'b0);
        ticks(2);
        strobe(1'b1, 64'hA2, 1'b1, 1'b1, 64'hB1, 1'b1);
        ticks(2);
        strobe(1'b1, 64'hA3, 1'b1, 1'b0, 64'h0, 1'b0);
        ticks(12);
        check("fair_issues", 64'(iss_log.size() - b), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("fair_issue%0d", i), iss_log[b+i], fair_exp[i]);
        check("fair_overrun0", 64'(ovr0 - o0), 64'd1);
        check("fair_overrun1", 64'(ovr1 - o1), 64'd0);
        drain("fair");

        // Overrun: port 1 A then B while port 0 is being serviced
        do_reset();
        b  = iss_log.size();
        o1 = ovr1;
        strobe(1'b1, 64'h0000_0000_0000_0C0C, 1'b1, 1'b0, 64'h0, 1'b0);
        strobe(1'b0, 64'h0, 1'b0, 1'b1, 64'h0000_0AAA_0000_0AAA, 1'b0);
        strobe(1'b0, 64'h0, 1'b0, 1'b1, 64'h0000_0BBB_0000_0BBB, 1'b1);
        ticks(10);
        check("ovr_pulses1", 64'(ovr1 - o1), 64'd1);
        check("ovr_issues", 64'(iss_log.size() - b), 64'd2);
        check("ovr_issue0", iss_log[b], 64'h0000_0000_0000_0C0C);
        check("ovr_issue1", iss_log[b+1], 64'h0000_0BBB_0000_0BBB);
        drain("ovr");

        // Same-port strobe during its own ISSUE cycle: kept pending, no overrun
        b  = iss_log.size();
        o0 = ovr0;
        strobe(1'b1, 64'h0000_0000_0000_0111, 1'b1, 1'b0, 64'h0, 1'b0);
        tick();
        strobe(1'b1, 64'h0000_0000_0000_0222, 1'b1, 1'b0, 64'h0, 1'b0);
        ticks(8);
        check("issrst_issues", 64'(iss_log.size() - b), 64'd2);
        check("issrst_second", iss_log[b+1], 64'h0000_0000_0000_0222);
        check("issrst_overrun0", 64'(ovr0 - o0), 64'd0);
        drain("issrst");

        // Timeout: presence drops 16 cycles after the last strobe
        do_reset();
        strobe(1'b1, 64'h0000_0000_0000_0345, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) begin
                check("tmo_present_k15", 64'(present[0]), 64'd1);
                check("tmo_btn0_k15", 64'(btn0), 64'h345);
            end
            if (k == 16) begin
                check("tmo_present_k16", 64'(present[0]), 64'd0);
                check("tmo_btn0_k16", 64'(btn0), 64'd0);
            end
        end
        drain("tmo");
        strobe(1'b1, 64'h0000_0000_0000_0567, 1'b1, 1'b0, 64'h0, 1'b0);
        ticks(4);
        check("tmo_restore_present", 64'(present[0]), 64'd1);
        check("tmo_restore_btn0", 64'(btn0), 64'h567);
        drain("tmo_restore");

        // Reset asserted while in WAIT
        strobe(1'b1, 64'h0000_0000_0000_0789, 1'b0, 1'b0, 64'h0, 1'b0);
        ticks(2);
        rst_n = 1'b0;
        #1;
        check("midrst_btn0", 64'(btn0), 64'd0);
        check("midrst_present", 64'(present), 64'd0);
        check("midrst_update", 64'(update), 64'd0);
        check("midrst_overrun", 64'(overrun), 64'd0);
        check("midrst_dec_valid", 64'(dec_if.dec_valid), 64'd0);
        check("midrst_dec_report", dec_if.dec_report, 64'd0);
        ticks(2);
        rst_n = 1'b1;
        b  = iss_log.size();
        u0 = upd_log.size();
        ticks(10);
        check("midrst_no_issue", 64'(iss_log.size() - b), 64'd0);
        check("midrst_no_update", 64'(upd_log.size() - u0), 64'd0);
        drain("midrst");
        strobe(1'b1, 64'h0000_0000_0000_09AB, 1'b1, 1'b0, 64'h0, 1'b0);
        ticks(6);
        check("midrst_new_issues", 64'(iss_log.size() - b), 64'd1);
        check("midrst_new_report", iss_log[b], 64'h0000_0000_0000_09AB);
        drain("midrst_new");

        check("never_both_updates", 64'(conc_cnt), 64'd0);
        check("dec_valid_single_cycle", 64'(long_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/usbh_report_arbiter.md
Name: usbh_report_arbiter

Overview:
Shares one gamepad HID report decoder between two USB host ports. Each port gets a one-deep report buffer, and a round-robin FSM feeds buffered reports to the decoder one at a time. The FSM captures the decoded 12-bit button word into a per-pad output register. It also tracks per-pad liveness with a timeout. Sits between the USB host report sources and the gamepad register interface.

Parameters:
DEC_LATENCY, 1, cycles from decoder valid strobe to decoder button output being valid (1..4)
TIMEOUT_CYCLES, 2400000, cycles without a report before a pad is declared absent (>=16)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_report0  in  64  port 0 HID report
i_report0_valid  in  1  port 0 report strobe, one cycle
i_report1  in  64  port 1 HID report
i_report1_valid  in  1  port 1 report strobe, one cycle
o_dec_report  out  64  report to shared decoder
o_dec_valid  out  1  decoder report strobe
i_dec_btn  in  12  decoder button word
o_btn0  out  12  pad 0 buttons
o_btn1  out  12  pad 1 buttons
o_present  out  2  per-pad liveness
o_update  out  2  one-cycle pulse when o_btnN is written from the decoder
o_overrun  out  2  one-cycle pulse when a pending report is overwritten

Behaviour:
- Reset: o_btn0 = o_btn1 = 0, o_present = 0, o_update = 0, o_overrun = 0, o_dec_valid = 0, o_dec_report = 0, both pending flags = 0, FSM in IDLE, rr_last = 1 so port 0 wins first, timeout counters = 0.
- Capture: on i_reportN_valid, buffer N takes the data and pending[N] is set at the end of that cycle.
- Overrun: if pending[N] is already set when a strobe arrives, the new data overwrites the buffer and o_overrun[N] pulses the next cycle. Newest report wins.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE: if any pending bit is set, grant a port. With one pending, grant that port. With both pending, grant the port != rr_last. Record rr_last = grant, go to ISSUE.
- ISSUE (exactly 1 cycle): o_dec_valid = 1 and o_dec_report = buffer[grant], registered. Clear pending[grant], unless a new strobe for the same port arrives in this cycle; then the new data is buffered and pending stays set. Load the wait counter with DEC_LATENCY, go to WAIT.
- WAIT: decrement each cycle. When the count reaches 1, sample i_dec_btn into o_btn[grant], set o_present[grant] = 1, pulse o_update[grant] the next cycle, and return to IDLE.
- Net latency: o_btnN updates DEC_LATENCY + 1 cycles after the ISSUE cycle. Minimum report-strobe to o_btnN latency is DEC_LATENCY + 3 cycles.
- The decoder is never given a second valid before the previous result has been captured, so it needs no handshake.
- Outside ISSUE, o_dec_valid = 0 and o_dec_report holds its last value.
- Timeout: each port has a counter of width $clog2(TIMEOUT_CYCLES + 1).
  - The counter clears on i_reportN_valid; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: o_present[N] = 0 and o_btnN = 0.
  - If a WAIT capture for port N coincides with the timeout cycle, the capture wins.
- Reset mid-operation clears everything asynchronously. No report is issued after reset until a new strobe arrives.
- Simultaneous strobes on both ports are both buffered; they are serviced in round-robin order.

Decomposition:
- Shared package usbh_gamepad_pkg: BTN_W = 12, REPORT_W = 64, state encoding localparams (IDLE/ISSUE/WAIT), default TIMEOUT_CYCLES.
- One natural sub-module: usbh_report_slot. It holds one port's 64-bit buffer, pending flag, overrun pulse and timeout counter/present logic, and is instantiated twice. The FSM and round-robin logic stay in the top.
- The decoder is instantiated outside this block and wired to o_dec_report / o_dec_valid / i_dec_btn.

Test Plan:
- Single report: port 0 strobe carrying hat=2, bit44=1; stub decoder with DEC_LATENCY=1 -> o_dec_valid is high for exactly 1 cycle, o_update[0] pulses at strobe+4, o_btn0 = decoder output, o_present = 2'b01.
- Simultaneous strobes on ports 0 and 1 after reset -> port 0 issued first, port 1 issued on the second ISSUE. Both o_update pulses fire with correct data and are never concurrent.
- Back-to-back fairness: port 0 strobes every 3 cycles while port 1 holds pending -> grants alternate 0,1,0,1. Port 1 is not starved.
- Overrun: two port 1 strobes with data A then B while the FSM is busy with port 0 -> o_overrun[1] pulses once, and only B reaches o_dec_report.
- Timeout: TIMEOUT_CYCLES=16, one report on port 0, then silence -> o_present[0] drops and o_btn0 = 0 exactly 16 cycles after the strobe. A new strobe restores presence.
- Reset mid-WAIT: assert i_rst_n=0 during WAIT with DEC_LATENCY=3 -> all outputs go to 0 immediately. No o_update follows after release, and o_dec_valid stays 0 until a new strobe.
